// File: rtl/banner_scroller_pkg.sv
// Shared constants, FSM state type and banner ROM contents for the scroller.
package banner_scroller_pkg;

    localparam int unsigned BANNER_ROWS  = 15;
    localparam int unsigned BANNER_WIDTH = 71;
    localparam int unsigned WIN          = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    // Banner image; bit BANNER_WIDTH-1 is the leftmost column.
    function automatic logic [BANNER_WIDTH-1:0] banner_row(input logic [4:0] r);
        case (r)
            5'd0:    return {17'b0, 6'h3F, 3'b0, 9'h1FF, 30'b0, 6'h3F};
            5'd3:    return {2'b11, 12'b0, 3'b111, {27{2'b01}}};
            default: return (r < 5'(BANNER_ROWS)) ?
                         {r[3:0], 3'b101, 64'h0123_4567_89AB_CDEF ^ {16{r[3:0]}}} : '0;
        endcase
    endfunction

endpackage

// File: rtl/banner_window.sv
// Combinational extractor of a WIN-pixel window at a wrapping column offset.
module banner_window #(
    parameter int unsigned WIDTH = 71,
    parameter int unsigned WIN   = 16
) (
    input  logic [WIDTH-1:0] word,
    input  logic [6:0]       offset,
    output logic [WIN-1:0]   pixels
);

    localparam int unsigned SH_W = $clog2(2 * WIDTH + 1);

    logic [2*WIDTH-1:0] doubled;
    logic [SH_W-1:0]    shamt;

    // Column c of the doubled word sits at bit 2*WIDTH-1-c, so the window
    // starting at column offset lands in the low WIN bits after this shift.
    assign doubled = {word, word};
    assign shamt   = SH_W'(2 * WIDTH - WIN) - SH_W'(offset);
    assign pixels  = WIN'(doubled >> shamt);

endmodule

// File: rtl/banner_scroller.sv
// Walks the banner ROM, presents scrolled rows over valid/ready, steps scroll per frame.
module banner_scroller #(
    parameter int unsigned ROWS       = banner_scroller_pkg::BANNER_ROWS,
    parameter int unsigned WIDTH      = banner_scroller_pkg::BANNER_WIDTH,
    parameter int unsigned WIN        = banner_scroller_pkg::WIN,
    parameter int unsigned STEP_TICKS = 2000000,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [3:0]        row_index,
    output logic [WIN-1:0]    row_pixels,
    output logic [6:0]        offset,
    output logic              frame_done
);

    import banner_scroller_pkg::*;

    state_t         state;
    logic [3:0]     row;
    logic [31:0]    timer;
    logic           pending;
    logic           expire;
    logic [WIN-1:0] window;

    banner_window #(
        .WIDTH(WIDTH),
        .WIN  (WIN)
    ) u_window (
        .word  (rom_data),
        .offset(offset),
        .pixels(window)
    );

    assign expire = en && (timer == 32'(STEP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            row         <= '0;
            rom_address <= '0;
            row_index   <= '0;
            row_pixels  <= '0;
            row_valid   <= 1'b0;
            offset      <= '0;
            frame_done  <= 1'b0;
            timer       <= '0;
            pending     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                timer <= expire ? '0 : timer + 32'd1;
            end
            if (expire) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (en) begin
                        row   <= '0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    rom_address <= ADDR_W'(row);
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    row_pixels <= window;
                    row_index  <= row;
                    row_valid  <= 1'b1;
                    state      <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        if (row == 4'(ROWS - 1)) begin
                            frame_done <= 1'b1;
                            // An expiry on this very edge is folded in here and
                            // overrides the pending set above.
                            if (pending || expire) begin
                                offset  <= (offset == 7'(WIDTH - 1)) ? '0 : offset + 7'd1;
                                pending <= 1'b0;
                            end
                            state <= S_IDLE;
                        end else begin
                            row   <= row + 4'd1;
                            state <= S_ADDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller against a registered-address model of the banner ROM.
module tb_banner_scroller;

    import banner_scroller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        row_ready;
    logic [4:0]  rom_address;
    logic [70:0] rom_data;
    logic        row_valid;
    logic [3:0]  row_index;
    logic [15:0] row_pixels;
    logic [6:0]  offset;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    always_ff @(posedge clk) rom_data <= banner_row(rom_address);

    banner_scroller #(
        .ROWS      (15),
        .WIDTH     (71),
        .WIN       (16),
        .STEP_TICKS(3),
        .ADDR_W    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_index  (row_index),
        .row_pixels (row_pixels),
        .offset     (offset),
        .frame_done (frame_done)
    );

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [15:0] exp_window(input logic [70:0] w, input int off);
        logic [15:0] p;
        for (int j = 0; j < 16; j++) p[15-j] = w[70 - ((off + j) % 71)];
        return p;
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (row_valid) begin
                ok = 1'b1;
                return;
            end
        end
        check_vec("valid_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs();
        check_vec("rst_address", rom_address, 0);
        check_vec("rst_valid", row_valid, 0);
        check_vec("rst_index", row_index, 0);
        check_vec("rst_pixels", row_pixels, 0);
        check_vec("rst_offset", offset, 0);
        check_vec("rst_frame_done", frame_done, 0);
    endtask

    task automatic run_frame(input int off, input int bp_row, input int drop_en_row);
        bit          ok;
        int          t_prev;
        int          exp_period;
        logic [15:0] exp_pix;
        t_prev = 0;
        for (int r = 0; r < 15; r++) begin
            wait_valid(ok);
            if (!ok) return;
            if (r == drop_en_row) en = 1'b0;
            exp_pix = exp_window(banner_row(5'(r)), off);
            check_vec("address", rom_address, r);
            check_vec("row_index", row_index, r);
            check_vec("row_pixels", row_pixels, exp_pix);
            check_vec("offset_stable", offset, off);
            check_vec("frame_done_low", frame_done, 0);
            if (r > 0) begin
                exp_period = (r - 1 == bp_row) ? 11 : 4;
                check_vec("row_period", cycle - t_prev, exp_period);
            end
            t_prev = cycle;
            if (r == 0 && off == 0)  check_vec("row0_off0", row_pixels, 16'h0000);
            if (r == 3 && off == 0)  check_vec("row3_off0", row_pixels, 16'hC003);
            if (r == 0 && off == 10) check_vec("row0_off10", row_pixels, 16'h01F8);
            if (r == 0 && off == 65) check_vec("row0_off65", row_pixels, 16'hFC00);
            if (r == bp_row) begin
                row_ready = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    check_vec("bp_valid", row_valid, 1);
                    check_vec("bp_pixels", row_pixels, exp_pix);
                    check_vec("bp_index", row_index, r);
                    check_vec("bp_address", rom_address, r);
                end
                row_ready = 1'b1;
            end
            @(negedge clk);
            check_vec("valid_drop", row_valid, 0);
        end
        check_vec("frame_done_pulse", frame_done, 1);
        check_vec("pending_clear", dut.pending, 0);
        check_vec("offset_step", offset, (off == 70) ? 0 : off + 1);
        @(negedge clk);
        check_vec("frame_done_one_cycle", frame_done, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        en        = 1'b0;
        row_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        en  = 1'b1;

        // 71 frames walk offsets 0..70; backpressure on row 5 of the offset-2 frame.
        for (int f = 0; f < 71; f++) run_frame(f, (f == 2) ? 5 : -1, -1);
        // Offset has wrapped to 0; en drops mid-frame, the frame still completes.
        run_frame(0, -1, 3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_vec("idle_no_valid", row_valid, 0);
        end
        check_vec("idle_address", rom_address, 14);

        // Reset while row 7 is being presented.
        en = 1'b1;
        for (int r = 0; r < 8; r++) wait_valid(ok);
        check_vec("pre_rst_index", row_index, 7);
        row_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst       = 1'b0;
        row_ready = 1'b1;
        wait_valid(ok);
        check_vec("restart_index", row_index, 0);
        check_vec("restart_address", rom_address, 0);
        check_vec("restart_pixels", row_pixels, exp_window(banner_row(5'd0), 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/banner_scroller.md
Name: banner_scroller

Overview:
Consumer stage for a 15-row x 71-bit banner ROM. The ROM has a registered address, so its data appears one cycle after it latches the address.
- Walks the ROM rows, extracts a WIN-pixel horizontal window at the current scroll offset, and hands each row to the LED-matrix row driver over a valid/ready handshake.
- Advances the scroll offset by one column per STEP_TICKS clocks, applied only at frame boundaries so a frame never tears.

Parameters:
ROWS, 15, number of ROM rows per frame
WIDTH, 71, ROM word width; bit WIDTH-1 is the leftmost column
WIN, 16, visible window width in pixels
STEP_TICKS, 2000000, clocks per scroll step
ADDR_W, 5, ROM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; sampled only in IDLE
rom_address  out  ADDR_W  row address to the ROM (registered)
rom_data  in  WIDTH  ROM word, valid 2 edges after rom_address changes
row_valid  out  1  row_pixels/row_index valid
row_ready  in  1  downstream accepts the row
row_index  out  4  row number 0..ROWS-1
row_pixels  out  WIN  window; bit WIN-1 is the leftmost pixel
offset  out  7  current scroll column, 0..WIDTH-1
frame_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - rom_address=0, row_index=0, row_pixels=0, row_valid=0, offset=0, frame_done=0.
  - Scroll timer=0, pending=0.
  - Applies mid-operation too: row_valid drops at that same edge.
- FSM states: IDLE, ADDR, WAIT, CAPTURE, PRESENT.
  - IDLE: if en, go to ADDR with row=0.
  - ADDR: rom_address<=row; go to WAIT.
  - WAIT: ROM latches the address at this edge; go to CAPTURE.
  - CAPTURE: row_pixels<=window(rom_data, offset); row_index<=row; row_valid<=1; go to PRESENT.
  - PRESENT: hold row_valid, row_pixels and row_index stable until row_valid&&row_ready at an edge. At that edge row_valid<=0, then:
    - if row<ROWS-1: row+1, go to ADDR;
    - else: frame_done<=1 for one cycle, apply the scroll step, go to IDLE.
- Latency:
  - rom_address updates at edge N; rom_data is sampled at edge N+2; row_valid is high from edge N+2.
  - With row_ready held at 1, a row completes every 4 cycles.
- Window: row_pixels[WIN-1-j] = rom_data[WIDTH-1-((offset+j) mod WIDTH)] for j=0..WIN-1.
  - Column indices wrap modulo WIDTH.
  - Implement with the doubled word {rom_data,rom_data} and a right shift; no division.
- Scroll timer:
  - Counts 0..STEP_TICKS-1 while en=1 and frozen while en=0.
  - On wrap it sets pending.
  - At frame end: if pending, offset<=(offset==WIDTH-1)?0:offset+1 and pending is cleared.
  - Several expiries within one frame collapse to a single step.
  - If expiry coincides with the frame-end edge, the step is applied in that same edge and pending ends at 0.
- en deasserted mid-frame: the current frame completes (all ROWS rows), then the FSM stays in IDLE.
- row_ready is ignored while row_valid=0.
- row_index width of 4 bits covers ROWS up to 16.

Decomposition:
- Shared package:
  - BANNER_ROWS=15, BANNER_WIDTH=71, WIN=16.
  - FSM state encoding (3-bit localparams).
- Sub-module banner_window: combinational extractor taking (word[WIDTH], offset[7]) and returning pixels[WIN], so it can be unit-tested alone.
- Timer, FSM and handshake registers stay in banner_scroller.

Test Plan:
Bench models the 15x71 banner ROM with a registered address; contents are per the shared package constants (row 0 = 17 zeros, 6 ones, 3 zeros, 9 ones, ...; row 3 begins 11, 12 zeros, 111).
- Reset then en=1, row_ready=1, offset=0 -> rom_address sequence 0..14, one row per 4 cycles; row 0 pixels=16'h0000; row 3 pixels=16'hC003; frame_done pulses once after row 14.
- Force offset=10 via STEP_TICKS=1 and 10 frames -> row 0 pixels=16'h01F8.
- Wrap case: offset=65 -> row 0 pixels=16'hFC00; offset 70 followed by a step -> offset=0.
- Backpressure: row_ready=0 for 7 cycles on row 5 -> row_valid, row_pixels and row_index stay stable for all 7 cycles; no address change; acceptance on the 8th cycle.
- STEP_TICKS=3 with frame length >3 cycles -> offset advances exactly 1 per frame, never mid-frame; an expiry on the frame-end edge leaves pending=0.
- rst pulsed while in PRESENT at row 7 -> next cycle all outputs are at reset values; after release with en=1 the walk restarts from row 0.
